// File: rtl/past_gate_checker.sv
// past_gate_checker: done |=> out == $past(q, DEPTH, enable) checker with pass/fail/skip pulses, saturating counters and q[0] edge flags under PAST_GATE_CHECKER_EDGE_EN
module past_gate_checker #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  input  logic             done,
  input  logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] past_q,
  output logic             past_valid,
  output logic             chk_pass,
  output logic             chk_fail,
  output logic             chk_skip,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             rose,
  output logic             fell,
  output logic             stable
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] q_q, q_d;
  logic [DEPTH-1:0][WIDTH-1:0] hist_q, hist_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pend_q, pend_d, pass_q, pass_d, fail_q, fail_d, skip_q, skip_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;
  assign q          = q_q;
  assign past_q     = hist_q[DEPTH-1];
  assign past_valid = cnt_q == CW'(DEPTH);
  assign chk_pass   = pass_q;
  assign chk_fail   = fail_q;
  assign chk_skip   = skip_q;
  assign pass_cnt   = pass_cnt_q;
  assign fail_cnt   = fail_cnt_q;
  always_comb begin
    q_d       = enable ? d : q_q;
    hist_d[0] = enable ? q_q : hist_q[0];
    for (int k = 1; k < DEPTH; k++) hist_d[k] = enable ? hist_q[k-1] : hist_q[k];
    cnt_d      = enable && !past_valid ? cnt_q + CW'(1) : cnt_q;
    pend_d     = done;
    pass_d     = pend_q && past_valid && out == past_q;
    fail_d     = pend_q && past_valid && out != past_q;
    skip_d     = pend_q && !past_valid;
    pass_cnt_d = pass_d && !(&pass_cnt_q) ? pass_cnt_q + CNT_W'(1) : pass_cnt_q;
    fail_cnt_d = fail_d && !(&fail_cnt_q) ? fail_cnt_q + CNT_W'(1) : fail_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q        <= '0;
      hist_q     <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      skip_q     <= 1'b0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      q_q        <= q_d;
      hist_q     <= hist_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      skip_q     <= skip_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end
`ifdef PAST_GATE_CHECKER_EDGE_EN
  logic prev_q0_q, prev_q0_d;
  always_comb prev_q0_d = q_q[0];
  always_ff @(posedge clk) begin
    if (rst) prev_q0_q <= 1'b0;
    else prev_q0_q <= prev_q0_d;
  end
  assign rose   = q_q[0] & ~prev_q0_q;
  assign fell   = ~q_q[0] & prev_q0_q;
  assign stable = q_q[0] == prev_q0_q;
`else
  assign rose   = 1'b0;
  assign fell   = 1'b0;
  assign stable = 1'b1;
`endif
endmodule
